// File: rtl/instr_fetch.sv
// instr_fetch: RV32 fetch sequencer (pc -> memory read -> instruction register); FETCH_ALIGN_CHECK_EN adds misaligned-pc faults
module instr_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_start,
  input  logic              flush,
  input  logic              instr_ack,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_cause
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD, FAULT} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] instr_n;
  logic [1:0] cause_n;
  logic [ADDR_W-1:0] pc_word;
  logic misaligned, timeout, accept;
  assign pc_word = pc & ~ADDR_W'(3);
`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = pc[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign timeout = cnt == 8'(TIMEOUT_CYC - 1);
  assign accept = fetch_start && !flush && (state == IDLE || (state == HOLD && instr_ack));
  // next state, timeout counter and captured data; a response only beats a timeout when it arrives in time
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = mem_req_addr;
    instr_n = instr;
    cause_n = fault_cause;
    case (state)
      REQ: begin
        if (mem_req_ready) begin
          cnt_n = '0;
          state_n = flush ? DRAIN : WAIT;
        end else if (flush) state_n = IDLE;
      end
      WAIT: begin
        cnt_n = cnt + 8'd1;
        if (flush) state_n = mem_rsp_valid ? IDLE : DRAIN;
        else if (mem_rsp_valid) begin
          instr_n = mem_rsp_data;
          state_n = HOLD;
        end else if (timeout) begin
          state_n = FAULT;
          cause_n = 2'b01;
        end
      end
      DRAIN: begin
        cnt_n = cnt + 8'd1;
        if (mem_rsp_valid) state_n = IDLE;
        else if (timeout && !flush) begin
          state_n = FAULT;
          cause_n = 2'b01;
        end
      end
      HOLD: state_n = (flush || instr_ack) ? IDLE : HOLD;
      IDLE, FAULT: state_n = state;
      default: state_n = IDLE;
    endcase
    if (accept) begin
      state_n = misaligned ? FAULT : REQ;
      cause_n = misaligned ? 2'b10 : cause_n;
      addr_n = misaligned ? mem_req_addr : pc_word;
    end
  end
  // state register; every output is registered from the next state so nothing glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      instr <= DATA_W'(32'h0000_0013);
      instr_valid <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_req_valid <= state_n == REQ;
      mem_req_addr <= addr_n;
      instr <= instr_n;
      instr_valid <= state_n == HOLD;
      busy <= state_n inside {REQ, WAIT, DRAIN, HOLD};
      fault <= state_n == FAULT;
      fault_cause <= cause_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table, directed and random transaction checks of instr_fetch
module tb_instr_fetch;
  localparam int T = 4;
  logic clk = 0, rst = 0;
  logic [31:0] pc = 0, mem_rsp_data = 0;
  logic fetch_start = 0, flush = 0, instr_ack = 0, mem_req_ready = 0, mem_rsp_valid = 0;
  logic mem_req_valid, instr_valid, busy, fault;
  logic [31:0] mem_req_addr, instr;
  logic [1:0] fault_cause;
  int vecs = 0, miscmp = 0;
  logic [31:0] model_instr;
  typedef struct {
    logic [31:0] pc, data;
    int rd, sd, fm;
    logic [31:0] ea, ei;
  } vec_t;
  vec_t tbl[6];

  instr_fetch #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_start(fetch_start), .flush(flush),
    .instr_ack(instr_ack), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr(instr), .instr_valid(instr_valid), .busy(busy), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      miscmp++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_req_valid"}, mem_req_valid, 0);
    chk({n, "_req_addr"}, mem_req_addr, 0);
    chk({n, "_instr"}, instr, 32'h13);
    chk({n, "_instr_valid"}, instr_valid, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_fault"}, fault, 0);
    chk({n, "_cause"}, fault_cause, 0);
  endtask

  // fm: 0 normal, 1 flush in WAIT then late rsp, 2 flush in REQ before ready, 3 flush with rsp
  task automatic fetch(input logic [31:0] p, d, input int rd, sd, fm,
                       input logic [31:0] ea, ei, input bit hold);
    pc = p;
    fetch_start = 1;
    tick;
    fetch_start = 0;
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, ea);
    if (fm == 2) begin
      flush = 1;
      tick;
      flush = 0;
      chk("wd_valid", mem_req_valid, 0);
      chk("wd_busy", busy, 0);
      chk("wd_instr", instr, ei);
      return;
    end
    repeat (rd) begin
      tick;
      chk("req_stable_valid", mem_req_valid, 1);
      chk("req_stable_addr", mem_req_addr, ea);
    end
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    chk("wait_valid", mem_req_valid, 0);
    chk("wait_busy", busy, 1);
    if (fm == 1) begin
      flush = 1;
      tick;
      flush = 0;
      chk("drain_busy", busy, 1);
    end
    repeat (sd) tick;
    mem_rsp_valid = 1;
    mem_rsp_data = d;
    flush = fm == 3;
    tick;
    mem_rsp_valid = 0;
    flush = 0;
    if (fm != 0) begin
      chk("disc_busy", busy, 0);
      chk("disc_ivalid", instr_valid, 0);
      chk("disc_instr", instr, ei);
      return;
    end
    chk("hold_ivalid", instr_valid, 1);
    chk("hold_instr", instr, ei);
    chk("hold_busy", busy, 1);
    if (!hold) begin
      instr_ack = 1;
      tick;
      instr_ack = 0;
      chk("ack_ivalid", instr_valid, 0);
      chk("ack_busy", busy, 0);
      chk("ack_instr", instr, ei);
    end
  endtask

  initial begin
    tbl[0] = '{32'h10, 32'h0050_0093, 0, 1, 0, 32'h10, 32'h0050_0093};
    tbl[1] = '{32'h20, 32'hDEAD_BEEF, 1, 2, 1, 32'h20, 32'h0050_0093};
    tbl[2] = '{32'h24, 32'h00A0_0113, 2, 0, 0, 32'h24, 32'h00A0_0113};
    tbl[3] = '{32'h30, 32'h1111_1111, 0, 0, 2, 32'h30, 32'h00A0_0113};
    tbl[4] = '{32'h34, 32'h2222_2222, 1, 1, 3, 32'h34, 32'h00A0_0113};
    tbl[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 3, 2, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
    #2 rst = 1;
    #1 chk_reset("rst");
    tick;
    rst = 0;
    mem_rsp_valid = 1;
    mem_rsp_data = 32'hDEAD_BEEF;
    tick;
    mem_rsp_valid = 0;
    chk("idle_rsp_instr", instr, 32'h13);
    chk("idle_rsp_ivalid", instr_valid, 0);
    for (int i = 0; i < 6; i++)
      fetch(tbl[i].pc, tbl[i].data, tbl[i].rd, tbl[i].sd, tbl[i].fm, tbl[i].ea, tbl[i].ei, 0);
    fetch(32'h50, 32'h0010_8093, 0, 0, 0, 32'h50, 32'h0010_8093, 1);
    instr_ack = 1;
    fetch_start = 1;
    pc = 32'h14;
    tick;
    instr_ack = 0;
    fetch_start = 0;
    chk("b2b_req_valid", mem_req_valid, 1);
    chk("b2b_addr", mem_req_addr, 32'h14);
    chk("b2b_ivalid", instr_valid, 0);
    chk("b2b_busy", busy, 1);
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    mem_rsp_valid = 1;
    mem_rsp_data = 32'h0020_8113;
    tick;
    mem_rsp_valid = 0;
    chk("b2b_instr", instr, 32'h0020_8113);
    chk("b2b_hold", instr_valid, 1);
    flush = 1;
    instr_ack = 1;
    fetch_start = 1;
    pc = 32'h60;
    tick;
    flush = 0;
    instr_ack = 0;
    fetch_start = 0;
    chk("hflush_ivalid", instr_valid, 0);
    chk("hflush_req", mem_req_valid, 0);
    chk("hflush_busy", busy, 0);
    chk("hflush_instr", instr, 32'h0020_8113);
    pc = 32'h40;
    fetch_start = 1;
    tick;
    fetch_start = 0;
    chk("fr_req", mem_req_valid, 1);
    mem_req_ready = 1;
    flush = 1;
    tick;
    mem_req_ready = 0;
    flush = 0;
    chk("fr_valid", mem_req_valid, 0);
    chk("fr_busy", busy, 1);
    fetch_start = 1;
    pc = 32'h44;
    tick;
    fetch_start = 0;
    chk("fr_ignore_start", mem_req_valid, 0);
    chk("fr_addr", mem_req_addr, 32'h40);
    mem_rsp_valid = 1;
    mem_rsp_data = 32'hDEAD_BEEF;
    tick;
    mem_rsp_valid = 0;
    chk("fr_idle_busy", busy, 0);
    chk("fr_instr", instr, 32'h0020_8113);
    chk("fr_ivalid", instr_valid, 0);
    tick;
    chk("fr_no_req", mem_req_valid, 0);
    model_instr = 32'h0020_8113;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] p, d, ei;
      int fm;
      p = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      p[1:0] = 2'b00;
`endif
      d = $urandom;
      fm = $urandom_range(0, 3);
      ei = fm == 0 ? d : model_instr;
      fetch(p, d, $urandom_range(0, 3), $urandom_range(0, 2), fm, p & ~32'h3, ei, 0);
      model_instr = ei;
    end
    pc = 32'h80;
    fetch_start = 1;
    tick;
    fetch_start = 0;
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    repeat (T - 1) tick;
    chk("to_pre_fault", fault, 0);
    chk("to_pre_busy", busy, 1);
    tick;
    chk("to_fault", fault, 1);
    chk("to_cause", fault_cause, 2'b01);
    chk("to_busy", busy, 0);
    chk("to_ivalid", instr_valid, 0);
    fetch_start = 1;
    pc = 32'h84;
    tick;
    fetch_start = 0;
    chk("to_sticky", fault, 1);
    chk("to_no_req", mem_req_valid, 0);
    #2 rst = 1;
    #1 chk_reset("rst2");
    tick;
    rst = 0;
    tick;
`ifdef FETCH_ALIGN_CHECK_EN
    pc = 32'h12;
    fetch_start = 1;
    tick;
    fetch_start = 0;
    chk("mis_req", mem_req_valid, 0);
    chk("mis_fault", fault, 1);
    chk("mis_cause", fault_cause, 2'b10);
`else
    fetch(32'h12, 32'h0030_0193, 0, 0, 0, 32'h10, 32'h0030_0193, 0);
    chk("mis_no_fault", fault, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
